// File: rtl/fphub_to_ieee_converter_if.sv
// Stream bundle for the FPHUB -> IEEE converter: input word handshake and output word handshake.
// The master is the producer/consumer side; the slave is the converter.
interface fphub_to_ieee_converter_if #(
    parameter int M = 23,
    parameter int E = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [E+M:0]   in_hub;
    logic           out_valid;
    logic           out_ready;
    logic [E+M+1:0] out_ieee;
    logic [2:0]     out_flags;

    modport master (
        output in_valid, in_hub, out_ready,
        input  in_ready, out_valid, out_ieee, out_flags
    );

    modport slave (
        input  in_valid, in_hub, out_ready,
        output in_ready, out_valid, out_ieee, out_flags
    );
endinterface

// File: rtl/fphub_to_ieee_converter.sv
// Exact FPHUB -> IEEE-style converter, two-stage valid/ready pipeline (classify, assemble).
// Define FPHUB_CONV_STATS_EN to build the saturating NaN/Inf/flush statistics counters.
module fphub_to_ieee_converter #(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fphub_to_ieee_converter_if.slave bus,
    input  logic                     stats_clr,
    output logic [CNT_W-1:0]         nan_cnt,
    output logic [CNT_W-1:0]         inf_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_FLUSH,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // Input field split and classification
    logic         w_sign;
    logic [E-1:0] w_exp;
    logic [M-1:0] w_man;
    logic         w_exp_zero;
    logic         w_exp_ones;
    logic         w_man_zero;
    cls_t         w_cls;

    assign w_sign     = bus.in_hub[E+M];
    assign w_exp      = bus.in_hub[E+M-1:M];
    assign w_man      = bus.in_hub[M-1:0];
    assign w_exp_zero = (w_exp == '0);
    assign w_exp_ones = &w_exp;
    assign w_man_zero = (w_man == '0);

    always_comb begin
        w_cls = CLS_NORMAL;
        if (w_exp_zero)      w_cls = w_man_zero ? CLS_ZERO : CLS_FLUSH;
        else if (w_exp_ones) w_cls = w_man_zero ? CLS_INF  : CLS_NAN;
    end

    // Pipeline control: a stage advances when it is empty or the stage after it drains
    logic r_s1_v;
    logic r_s2_v;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_hs;

    assign w_s2_adv     = !r_s2_v || bus.out_ready;
    assign w_s1_adv     = !r_s1_v || w_s2_adv;
    assign bus.in_ready = w_s1_adv;
    assign w_in_hs      = bus.in_valid && w_s1_adv;

    // Stage 1 registers
    logic         r_s1_sign;
    logic [E-1:0] r_s1_exp;
    logic [M-1:0] r_s1_man;
    cls_t         r_s1_cls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_man  <= '0;
            r_s1_cls  <= CLS_ZERO;
        end else if (w_s1_adv) begin
            r_s1_v <= bus.in_valid;
            if (w_in_hs) begin
                r_s1_sign <= w_sign;
                r_s1_exp  <= w_exp;
                r_s1_man  <= w_man;
                r_s1_cls  <= w_cls;
            end
        end
    end

    // Stage 2 assembly; the implicit ILSB becomes the explicit fraction LSB
    logic [E+M+1:0] w_ieee;
    logic [2:0]     w_flags;

    always_comb begin
        w_ieee  = '0;
        w_flags = 3'b000;
        case (r_s1_cls)
            CLS_NORMAL: w_ieee = {r_s1_sign, r_s1_exp, r_s1_man, 1'b1};
            CLS_ZERO, CLS_FLUSH: begin
                w_ieee  = {r_s1_sign, {E{1'b0}}, {(M+1){1'b0}}};
                w_flags = 3'b001;
            end
            CLS_INF: begin
                w_ieee  = {r_s1_sign, {E{1'b1}}, {(M+1){1'b0}}};
                w_flags = 3'b010;
            end
            CLS_NAN: begin
                w_ieee  = {1'b0, {E{1'b1}}, 1'b1, {M{1'b0}}};
                w_flags = 3'b100;
            end
            default: begin
                w_ieee  = '0;
                w_flags = 3'b000;
            end
        endcase
    end

    logic [E+M+1:0] r_out_ieee;
    logic [2:0]     r_out_flags;
    logic           r_s2_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v      <= 1'b0;
            r_out_ieee  <= '0;
            r_out_flags <= 3'b000;
            r_s2_flush  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_out_ieee  <= w_ieee;
                r_out_flags <= w_flags;
                r_s2_flush  <= (r_s1_cls == CLS_FLUSH);
            end
        end
    end

    assign bus.out_valid = r_s2_v;
    assign bus.out_ieee  = r_out_ieee;
    assign bus.out_flags = r_out_flags;

`ifdef FPHUB_CONV_STATS_EN
    // Events are taken at the output handshake so a stalled hold is never recounted
    logic             w_out_hs;
    logic [CNT_W-1:0] r_nan_cnt;
    logic [CNT_W-1:0] r_inf_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_out_hs = r_s2_v && bus.out_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nan_cnt   <= '0;
            r_inf_cnt   <= '0;
            r_flush_cnt <= '0;
        end else if (stats_clr) begin
            r_nan_cnt   <= '0;
            r_inf_cnt   <= '0;
            r_flush_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_out_flags[2]) r_nan_cnt   <= sat_inc(r_nan_cnt);
            if (r_out_flags[1]) r_inf_cnt   <= sat_inc(r_inf_cnt);
            if (r_s2_flush)     r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    assign nan_cnt   = r_nan_cnt;
    assign inf_cnt   = r_inf_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    logic [1:0] w_unused_stats;
    assign w_unused_stats = {stats_clr, r_s2_flush};
    assign nan_cnt        = '0;
    assign inf_cnt        = '0;
    assign flush_cnt      = '0;
`endif

endmodule
